// File: rtl/input_debouncer_pkg.sv
// Shared types and defaults for the input debouncer.
// Optional push-on/push-off toggle: INPUT_DEBOUNCER_TOGGLE_EN.
package input_debouncer_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    CHK_HI    = 2'b01,
    STABLE_HI = 2'b10,
    CHK_LO    = 2'b11
  } deb_state_t;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

  function automatic logic is_chk(input deb_state_t st);
    return (st == CHK_HI) || (st == CHK_LO);
  endfunction

endpackage

// File: rtl/input_debouncer_channel.sv
// One channel: synchroniser, debounce FSM, edge pulses, toggle latch.
// Toggle latch present only with INPUT_DEBOUNCER_TOGGLE_EN.
module debounce_channel
  import input_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o,
  output logic toggle_o
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  deb_state_t       state_q;
  deb_state_t       state_n;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_n;

  logic level_q;
  logic level_n;
  logic rise_q;
  logic rise_n;
  logic fall_q;
  logic fall_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    unique case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_n = CHK_HI;
          cnt_n   = '0;
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_n = STABLE_LO;
        end else if (cnt_q == CNT_LAST) begin
          state_n = STABLE_HI;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_n = CHK_LO;
          cnt_n   = '0;
        end
      end
      CHK_LO: begin
        if (s) begin
          state_n = STABLE_HI;
        end else if (cnt_q == CNT_LAST) begin
          state_n = STABLE_LO;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: begin
        state_n = STABLE_LO;
        cnt_n   = '0;
      end
    endcase
  end

  // Pulses fire only on acceptance out of a CHK state.
  always_comb begin
    rise_n  = (state_q == CHK_HI) && (state_n == STABLE_HI);
    fall_n  = (state_q == CHK_LO) && (state_n == STABLE_LO);
    level_n = level_q;
    if (rise_n) level_n = 1'b1;
    if (fall_n) level_n = 1'b0;
    busy_o  = is_chk(state_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= level_n;
      rise_q  <= rise_n;
      fall_q  <= fall_n;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

`ifdef INPUT_DEBOUNCER_TOGGLE_EN
  logic toggle_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      toggle_q <= 1'b0;
    end else if (rise_n) begin
      toggle_q <= ~toggle_q;
    end
  end

  assign toggle_o = toggle_q;
`else
  assign toggle_o = 1'b0;
`endif

endmodule

// File: rtl/input_debouncer.sv
// Multi-channel synchronise/debounce front end for the NAND cell inputs.
// Optional toggle mode via INPUT_DEBOUNCER_TOGGLE_EN.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] raw_i,
  output logic [NUM_CH-1:0] level_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] fall_o,
  output logic [NUM_CH-1:0] busy_o,
  output logic [NUM_CH-1:0] toggle_o
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (raw_i[g]),
      .level_o (level_o[g]),
      .rise_o  (rise_o[g]),
      .fall_o  (fall_o[g]),
      .busy_o  (busy_o[g]),
      .toggle_o(toggle_o[g])
    );
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer (NUM_CH=2, SYNC=2, D=4).
// Table vectors, directed corner cases and a random run vs a run-length model.
module tb_input_debouncer;

  localparam int NCH  = 2;
  localparam int SYNC = 2;
  localparam int D    = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] raw = '0;
  logic [NCH-1:0] level;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] fall;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] toggle;

  input_debouncer #(
    .NUM_CH         (NCH),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (raw),
    .level_o (level),
    .rise_o  (rise),
    .fall_o  (fall),
    .busy_o  (busy),
    .toggle_o(toggle)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: a level flips after D+1 consecutive sampled edges disagreeing with it.
  bit sm [NCH][SYNC];
  int run[NCH];
  bit ml [NCH];
  bit mr [NCH];
  bit mf [NCH];
  bit mt [NCH];

`ifdef INPUT_DEBOUNCER_TOGGLE_EN
  localparam bit TOG_EN = 1'b1;
`else
  localparam bit TOG_EN = 1'b0;
`endif

  task automatic check(input string name, input logic [NCH-1:0] act,
                       input logic [NCH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NCH-1:0] pack(input bit v[NCH]);
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++) r[c] = v[c];
    return r;
  endfunction

  function automatic logic [NCH-1:0] mbusy();
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++) r[c] = (run[c] != 0);
    return r;
  endfunction

  task automatic step(input bit r, input logic [NCH-1:0] x);
    rst = r;
    raw = x;
    @(posedge clk);
    for (int c = 0; c < NCH; c++) begin
      mr[c] = 1'b0;
      mf[c] = 1'b0;
      if (r) begin
        for (int j = 0; j < SYNC; j++) sm[c][j] = 1'b0;
        run[c] = 0;
        ml[c]  = 1'b0;
        mt[c]  = 1'b0;
      end else begin
        if (sm[c][SYNC-1] != ml[c]) begin
          run[c]++;
          if (run[c] == D + 1) begin
            ml[c]  = sm[c][SYNC-1];
            mr[c]  = ml[c];
            mf[c]  = !ml[c];
            run[c] = 0;
            if (mr[c] && TOG_EN) mt[c] = !mt[c];
          end
        end else begin
          run[c] = 0;
        end
        for (int j = SYNC - 1; j > 0; j--) sm[c][j] = sm[c][j-1];
        sm[c][0] = x[c];
      end
    end
    #1;
    check("model_level",  level,  pack(ml));
    check("model_rise",   rise,   pack(mr));
    check("model_fall",   fall,   pack(mf));
    check("model_busy",   busy,   mbusy());
    check("model_toggle", toggle, pack(mt));
  endtask

  typedef struct {
    bit             r;
    logic [NCH-1:0] x;
    logic [NCH-1:0] l;
    logic [NCH-1:0] ri;
    logic [NCH-1:0] b;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit r, logic [NCH-1:0] x, logic [NCH-1:0] l,
                              logic [NCH-1:0] ri, logic [NCH-1:0] b);
    vec_t v;
    v.r = r; v.x = x; v.l = l; v.ri = ri; v.b = b;
    return v;
  endfunction

  int rise_cnt[NCH];
  int fall_cnt[NCH];
  int rise_at;
  int fall_at;
  logic [NCH-1:0] tog_seq[3];
  logic [NCH-1:0] cur;
  int             hold[NCH];

  initial begin
    // Reset then both channels accepted on the 6th edge after release.
    vt.push_back(mk(1, 2'b11, 2'b00, 2'b00, 2'b00));
    vt.push_back(mk(1, 2'b11, 2'b00, 2'b00, 2'b00));
    vt.push_back(mk(1, 2'b11, 2'b00, 2'b00, 2'b00));
    vt.push_back(mk(0, 2'b11, 2'b00, 2'b00, 2'b00));
    vt.push_back(mk(0, 2'b11, 2'b00, 2'b00, 2'b00));
    vt.push_back(mk(0, 2'b11, 2'b00, 2'b00, 2'b11));
    vt.push_back(mk(0, 2'b11, 2'b00, 2'b00, 2'b11));
    vt.push_back(mk(0, 2'b11, 2'b00, 2'b00, 2'b11));
    vt.push_back(mk(0, 2'b11, 2'b00, 2'b00, 2'b11));
    vt.push_back(mk(0, 2'b11, 2'b11, 2'b11, 2'b00));
    vt.push_back(mk(0, 2'b11, 2'b11, 2'b00, 2'b00));
    // Reset drops level silently, then a 4-cycle glitch on channel 0.
    vt.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b00));
    vt.push_back(mk(0, 2'b01, 2'b00, 2'b00, 2'b00));
    vt.push_back(mk(0, 2'b01, 2'b00, 2'b00, 2'b00));
    vt.push_back(mk(0, 2'b01, 2'b00, 2'b00, 2'b01));
    vt.push_back(mk(0, 2'b01, 2'b00, 2'b00, 2'b01));
    vt.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b01));
    vt.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b01));
    vt.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00));
    vt.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00));

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].r, vt[i].x);
      check($sformatf("vec%0d_level", i), level, vt[i].l);
      check($sformatf("vec%0d_rise", i),  rise,  vt[i].ri);
      check($sformatf("vec%0d_busy", i),  busy,  vt[i].b);
      check($sformatf("vec%0d_fall", i),  fall,  2'b00);
    end

    // Minimum accept: 5-cycle pulse on channel 0.
    rise_cnt[0] = 0; fall_cnt[0] = 0; rise_at = -1; fall_at = -1;
    for (int i = 0; i < 16; i++) begin
      step(0, (i < 5) ? 2'b01 : 2'b00);
      if (rise[0]) begin rise_cnt[0]++; rise_at = i; end
      if (fall[0]) begin fall_cnt[0]++; fall_at = i; end
    end
    check("min_rise_count", NCH'(rise_cnt[0]), NCH'(1));
    check("min_rise_at",    NCH'(rise_at),     NCH'(6));
    check("min_fall_count", NCH'(fall_cnt[0]), NCH'(1));
    checks++;
    if (fall_at != 11) begin
      failures++;
      $display("FAIL min_fall_at: got %0d expected 11", fall_at);
    end

    // Bounce on channel 1: 2-cycle toggles then hold high.
    for (int c = 0; c < NCH; c++) rise_cnt[c] = 0;
    rise_at = -1;
    for (int i = 0; i < 32; i++) begin
      step(0, {((i >= 20) || ((i / 2) % 2 == 0)), 1'b0});
      for (int c = 0; c < NCH; c++) if (rise[c]) rise_cnt[c]++;
      if (rise[1]) rise_at = i;
    end
    check("bounce_rise1_count", NCH'(rise_cnt[1]), NCH'(1));
    check("bounce_rise0_count", NCH'(rise_cnt[0]), NCH'(0));
    checks++;
    if (rise_at != 26) begin
      failures++;
      $display("FAIL bounce_rise_at: got %0d expected 26", rise_at);
    end
    check("bounce_level", level, 2'b10);

    // Reset mid-check on channel 0.
    step(1, 2'b00);
    for (int i = 0; i < 4; i++) step(0, 2'b01);
    check("midchk_busy_before", busy, 2'b01);
    step(1, 2'b01);
    check("midchk_level", level, 2'b00);
    check("midchk_busy",  busy,  2'b00);
    check("midchk_rise",  rise,  2'b00);
    rise_at = -1;
    for (int i = 0; i < 10; i++) begin
      step(0, 2'b01);
      if (rise[0] && rise_at < 0) rise_at = i;
    end
    checks++;
    if (rise_at != 6) begin
      failures++;
      $display("FAIL midchk_rise_at: got %0d expected 6", rise_at);
    end

    // Three accepted presses on channel 0.
    step(1, 2'b00);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 8; i++) step(0, 2'b01);
      tog_seq[p] = toggle;
      for (int i = 0; i < 8; i++) step(0, 2'b00);
    end
    check("toggle_p1", tog_seq[0], TOG_EN ? 2'b01 : 2'b00);
    check("toggle_p2", tog_seq[1], 2'b00);
    check("toggle_p3", tog_seq[2], TOG_EN ? 2'b01 : 2'b00);

    // Random run-length stimulus with occasional resets.
    cur = '0;
    for (int c = 0; c < NCH; c++) hold[c] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if (hold[c] == 0) begin
          cur[c]  = $urandom_range(1, 0);
          hold[c] = $urandom_range(8, 1);
        end
        hold[c]--;
      end
      step(($urandom_range(199, 0) == 0), cur);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
